// File: rtl/sfq_toggle_tx_if.sv
// Word handshake between clocked control logic and the SFQ toggle transmitter.
interface sfq_toggle_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/sfq_toggle_tx.sv
// Toggle-encoded SFQ pulse-line driver: one start pulse, then one pulse per
// '1' data bit (LSB first) in fixed-length slots, followed by idle guard slots.
module sfq_toggle_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLOT  = 4,
    parameter int unsigned GUARD = 2
) (
    input  logic           clk,
    input  logic           rst,
    sfq_toggle_tx_if.slave bus,
    output logic           out,
    output logic           busy,
    output logic           done
);
    localparam int unsigned SLOT_W  = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int unsigned BIT_W   = $clog2(WIDTH + 1);
    localparam int unsigned GUARD_W = (GUARD > 1) ? $clog2(GUARD) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(WIDTH);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BITS  = 2'd2,
        S_GUARD = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [SLOT_W-1:0]  slot_q,  slot_d;
    logic [BIT_W-1:0]   bit_q,   bit_d;
    logic [GUARD_W-1:0] guard_q, guard_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               out_q,   out_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic               accept_c;
    logic               slot_wrap_c;

    // Ready only while idle and not held in reset; reset wins over any accept.
    assign bus.in_ready = (state_q == S_IDLE) && !rst;
    assign accept_c     = bus.in_valid && bus.in_ready;
    assign slot_wrap_c  = (slot_q == SLOT_LAST);

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

    // Next-state, slot timing and pulse decisions.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        bit_d   = bit_q;
        guard_d = guard_q;
        shift_d = shift_q;
        out_d   = out_q;
        done_d  = 1'b0;

        // Slot counter free-runs 0..SLOT-1 for the whole frame.
        if (state_q != S_IDLE) begin
            slot_d = slot_wrap_c ? '0 : slot_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    shift_d = bus.in_data;
                    out_d   = ~out_q;
                    slot_d  = '0;
                    bit_d   = '0;
                    guard_d = '0;
                    state_d = S_START;
                end
            end

            S_START: begin
                // End of the start slot carries the decision for bit 0.
                if (slot_wrap_c) begin
                    out_d   = out_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = BIT_W'(1);
                    state_d = S_BITS;
                end
            end

            S_BITS: begin
                if (slot_wrap_c) begin
                    if (bit_q == BIT_LAST) begin
                        // Last data slot has elapsed; no pulse on this edge.
                        guard_d = '0;
                        state_d = S_GUARD;
                    end else begin
                        out_d   = out_q ^ shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end

            S_GUARD: begin
                if (slot_wrap_c) begin
                    if (guard_q == GUARD_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        guard_d = guard_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers; reset aborts any frame and drives out low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            bit_q   <= '0;
            guard_q <= '0;
            shift_q <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            bit_q   <= bit_d;
            guard_q <= guard_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Handshake ready and busy are never both high.
    a_ready_busy_excl: assert property (@(posedge clk) disable iff (rst)
        !(bus.in_ready && busy_q));

    // done is a single-cycle strobe.
    a_done_strobe: assert property (@(posedge clk) disable iff (rst)
        done_q |=> !done_q);

    // The line only toggles on an accept or on a slot boundary.
    a_toggle_on_slot: assert property (@(posedge clk) disable iff (rst)
        (out_d != out_q) |-> (accept_c || ((state_q != S_IDLE) && slot_wrap_c)));

endmodule

// File: tb/tb_sfq_toggle_tx.sv
// Directed bench for sfq_toggle_tx: default build plus a WIDTH=1/SLOT=2/GUARD=1 build.
`timescale 1ns/1ps
module tb_sfq_toggle_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic out_a, busy_a, done_a;
    logic out_b, busy_b, done_b;

    sfq_toggle_tx_if #(.WIDTH(8)) bus_a ();
    sfq_toggle_tx_if #(.WIDTH(1)) bus_b ();

    sfq_toggle_tx #(.WIDTH(8), .SLOT(4), .GUARD(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave),
        .out(out_a), .busy(busy_a), .done(done_a)
    );

    sfq_toggle_tx #(.WIDTH(1), .SLOT(2), .GUARD(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave),
        .out(out_b), .busy(busy_b), .done(done_b)
    );

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level after each edge, from a start level and a mask of toggle edges.
    function automatic logic [127:0] lvl_trace(input logic lvl0, input logic [127:0] tmask, input int n);
        logic l;
        logic [127:0] r;
        l = lvl0;
        r = '0;
        for (int k = 0; k < n; k++) begin
            l    = l ^ tmask[k];
            r[k] = l;
        end
        return r;
    endfunction

    function automatic logic [127:0] span(input int lo, input int hi);
        logic [127:0] r;
        r = '0;
        for (int k = lo; k <= hi; k++) r[k] = 1'b1;
        return r;
    endfunction

    // Samples the default build after E0..E(n-1); optional handshake noise while busy.
    task automatic record_a(input int n, input bit noise,
                            output logic [127:0] o_tr, output logic [127:0] d_tr,
                            output logic [127:0] b_tr, output logic [127:0] r_tr);
        o_tr = '0; d_tr = '0; b_tr = '0; r_tr = '0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick();
            o_tr[k] = out_a;
            d_tr[k] = done_a;
            b_tr[k] = busy_a;
            r_tr[k] = bus_a.in_ready;
            if (noise) begin
                bus_a.in_valid = (k < n - 1) ? 1'(k % 2) : 1'b0;
                bus_a.in_data  = 8'($urandom);
            end
        end
    endtask

    // Toggle spacing monitor on the small build.
    int   cyc      = 0;
    int   last_tgl = -1000;
    int   min_gap  = 1000;
    logic prev_b   = 1'b0;
    bit   mon_en   = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (mon_en && (out_b !== prev_b)) begin
            if (cyc - last_tgl < min_gap) min_gap = cyc - last_tgl;
            last_tgl = cyc;
        end
        prev_b = out_b;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] o_tr, d_tr, b_tr, r_tr, tm;
        logic         lvl_b;

        bus_a.in_valid = 1'b0; bus_a.in_data = 8'h00;
        bus_b.in_valid = 1'b0; bus_b.in_data = 1'b0;

        // Reset held 3 cycles, then 50 idle cycles: {out,busy,done,ready} per build.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", 128'({out_a, busy_a, done_a, bus_a.in_ready,
                                      out_b, busy_b, done_b, bus_b.in_ready}), 128'(8'b0000_0000));
        end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle", 128'({out_a, busy_a, done_a, bus_a.in_ready,
                                out_b, busy_b, done_b, bus_b.in_ready}), 128'(8'b0001_0001));
        end

        // Single frame 0xA5 from level 0: toggles at E0, E4, E12, E24, E32; done after E44.
        bus_a.in_valid = 1'b1; bus_a.in_data = 8'hA5;
        tick();
        bus_a.in_valid = 1'b0;
        record_a(45, 1'b0, o_tr, d_tr, b_tr, r_tr);
        tm = '0; tm[0] = 1'b1; tm[4] = 1'b1; tm[12] = 1'b1; tm[24] = 1'b1; tm[32] = 1'b1;
        check("a5_out",   o_tr, lvl_trace(1'b0, tm, 45));
        check("a5_done",  d_tr, 128'(1) << 44);
        check("a5_busy",  b_tr, span(0, 43));
        check("a5_ready", r_tr, 128'(1) << 44);

        // 0x00 then 0xFF with valid held: second accept at E45, 9 pulses; from level 1.
        bus_a.in_valid = 1'b1; bus_a.in_data = 8'h00;
        tick();
        bus_a.in_data = 8'hFF;
        record_a(90, 1'b0, o_tr, d_tr, b_tr, r_tr);
        bus_a.in_valid = 1'b0;
        tm = '0; tm[0] = 1'b1; tm[45] = 1'b1;
        for (int k = 1; k <= 8; k++) tm[45 + 4 * k] = 1'b1;
        check("b2b_out",   o_tr, lvl_trace(1'b1, tm, 90));
        check("b2b_done",  d_tr, (128'(1) << 44) | (128'(1) << 89));
        check("b2b_busy",  b_tr, span(0, 43) | span(45, 88));
        check("b2b_ready", r_tr, (128'(1) << 44) | (128'(1) << 89));
        check("b2b_final", 128'(out_a), 128'(1));

        // Handshake noise while busy: only 0x3C from the accept edge is sent; from level 1.
        bus_a.in_valid = 1'b1; bus_a.in_data = 8'h3C;
        tick();
        bus_a.in_valid = 1'b0;
        record_a(45, 1'b1, o_tr, d_tr, b_tr, r_tr);
        tm = '0; tm[0] = 1'b1; tm[12] = 1'b1; tm[16] = 1'b1; tm[20] = 1'b1; tm[24] = 1'b1;
        check("hs_out",  o_tr, lvl_trace(1'b1, tm, 45));
        check("hs_done", d_tr, 128'(1) << 44);
        check("hs_busy", b_tr, span(0, 43));

        // Reset mid-frame: 0x01 from level 0, rst sampled at E2 forces out low, no done.
        bus_a.in_valid = 1'b1; bus_a.in_data = 8'h01;
        tick();
        bus_a.in_valid = 1'b0;
        check("mid_e0_out", 128'(out_a), 128'(1));
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst", 128'({out_a, busy_a, done_a, bus_a.in_ready}), 128'(4'b0000));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_after", 128'({out_a, busy_a, done_a, bus_a.in_ready}), 128'(4'b0001));
        end
        bus_a.in_valid = 1'b1; bus_a.in_data = 8'h03;
        tick();
        bus_a.in_valid = 1'b0;
        record_a(45, 1'b0, o_tr, d_tr, b_tr, r_tr);
        tm = '0; tm[0] = 1'b1; tm[4] = 1'b1; tm[8] = 1'b1;
        check("mid_new_out",  o_tr, lvl_trace(1'b0, tm, 45));
        check("mid_new_done", d_tr, 128'(1) << 44);

        // Small build, data 1 from level 0: toggles at E0 and E2, done after E6.
        bus_b.in_valid = 1'b1; bus_b.in_data = 1'b1;
        tick();
        bus_b.in_valid = 1'b0;
        o_tr = '0; d_tr = '0; b_tr = '0;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) tick();
            o_tr[k] = out_b;
            d_tr[k] = done_b;
            b_tr[k] = busy_b;
        end
        tm = '0; tm[0] = 1'b1; tm[2] = 1'b1;
        check("sm_out",  o_tr, lvl_trace(1'b0, tm, 7));
        check("sm_done", d_tr, 128'(1) << 6);
        check("sm_busy", b_tr, span(0, 5));

        // 200 random small frames: length, final level, and toggle spacing.
        lvl_b  = 1'b0;
        mon_en = 1'b1;
        for (int f = 0; f < 200; f++) begin
            logic d;
            int   len;
            d = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) tick();
            bus_b.in_valid = 1'b1; bus_b.in_data = d;
            tick();
            bus_b.in_valid = 1'b0;
            lvl_b = lvl_b ^ 1'b1 ^ d;
            len = 0;
            for (int c = 1; (c <= 20) && (len == 0); c++) begin
                tick();
                if (done_b) len = c;
            end
            check("sm_rnd_len", 128'(len), 128'(6));
            check("sm_rnd_out", 128'(out_b), 128'(lvl_b));
        end
        check("sm_min_gap", 128'(min_gap >= 2), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule

// File: doc/sfq_toggle_tx.md
# sfq_toggle_tx

Synchronous-domain transmitter that drives a toggle-encoded SFQ pulse line: each change of level on `out` (rising or falling) is one pulse to the downstream transmission-line and receiver cells. It accepts a data word over a valid/ready handshake and emits a framed, fixed-slot pulse stream: one start pulse, then one pulse per '1' data bit, LSB first. It is the driving end of the pulse line, sitting between clocked test and control logic and the SFQ cell chain.

## Interface
- `WIDTH`, 8, data bits per frame (>=1)
- `SLOT`, 4, clock cycles per pulse slot (>=2); this is the minimum pulse spacing on `out`
- `GUARD`, 2, idle slots appended after the last data slot (>=1)
- `clk`  input  1  clock; all logic on rising edge
- `rst`  input  1  reset, synchronous, active-high
- `in_valid`  input  1  `in_data` holds a word to send
- `in_ready`  output  1  transmitter can accept; high only in IDLE and while `rst` is low
- `in_data`  input  WIDTH  word to serialize; sampled only on the accept edge
- `out`  output  1  toggle-encoded pulse line; registered
- `busy`  output  1  high from the accept edge until the return to IDLE
- `done`  output  1  single-cycle strobe on return to IDLE

## Operation
- States: IDLE, START, BITS, GUARD.
- Accept: `in_valid && in_ready` sampled at edge E0. At E0, latch `in_data` to a shift register, toggle `out` (start pulse), set slot counter to 0, and go to START.
- The slot counter counts 0..SLOT-1 and wraps. Every wrap edge ends a slot.
- START -> BITS at edge E(SLOT). At that edge, toggle `out` iff `data[0]`.
- BITS: bit i's toggle decision is made at edge E(SLOT*(i+1)); toggle iff `data[i]`. A '0' bit leaves `out` unchanged for the whole slot.
- After bit WIDTH-1's slot, at edge E(SLOT*(WIDTH+1)), BITS -> GUARD. No toggle occurs at this edge.
- GUARD lasts GUARD*SLOT cycles with no toggles. At edge E(SLOT*(WIDTH+1+GUARD)), go to IDLE and set `done` for one cycle.
- Pulses per frame = 1 + popcount(`in_data`). `out` is never forced back to 0 between frames; the next frame starts from the current level.
- `in_valid` is ignored outside IDLE. `in_data` changes after the accept edge have no effect.
- Reset has priority over accept and over all state updates.
- Reset values: state IDLE, `out`=0, `busy`=0, `done`=0, counters 0, shift register 0. `in_ready`=0 while `rst`=1.
- Reset mid-frame aborts the frame immediately. If `out` was 1, the reset edge drives it to 0, which the line sees as one spurious pulse. The paired receiver must be reset in the same cycle; this is documented behaviour, not suppressed.

## Timing
- Start-pulse latency: `out` changes at the accept edge itself and is visible in the following cycle.
- Minimum spacing between any two toggles is SLOT cycles.
- Frame length from accept edge to the `done` edge is SLOT*(WIDTH+1+GUARD) cycles. With defaults this is 44.
- `done` and `in_ready` are both high in the cycle after the frame-end edge. The earliest next accept is one cycle after `done` is set. Back-to-back period with defaults is 45 cycles.
- `busy` = (state != IDLE). It is registered with the state, so it is never high in the same cycle as `in_ready`.

## Test plan
- Reset then idle: hold `rst` 3 cycles, then `in_valid`=0 for 50 cycles -> `out`=0, `busy`=0, `done`=0 throughout; `in_ready`=0 during reset and 1 after.
- Single frame, 0xA5, defaults: `out` toggles 0->1 at E0, 1->0 at E4 (bit0), 0->1 at E12 (bit2), 1->0 at E24 (bit5), 0->1 at E32 (bit7). There is no other change; 5 pulses in total. `done` is set at E44 and `out` stays 1.
- Frame 0x00 then 0xFF, `in_valid` held high: first frame has only the start toggle at E0. Second accept is at E45. The second frame then toggles at E45 and at E45+4k for k=1..8 (9 pulses), and ends with `out`=1.
- Handshake: change `in_data` every cycle and pulse `in_valid` while `busy`=1 -> no accept and no effect on the in-flight frame. Only the value present on the accept edge is transmitted.
- Reset mid-frame: send 0x01, assert `rst` at E2 (`out`=1) -> `out`=0 at E2, state IDLE, no `done`. A new frame of 0x03 after release is transmitted normally from `out`=0.
- Parameter sweep: WIDTH=1, SLOT=2, GUARD=1 with data 1 -> toggles at E0 and E2, `done` at E6. Check that spacing between toggles is always >= SLOT across 200 random frames.
